// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared types, default sizes and helpers for the SPI mode-0
//               responder (spi_slave_mode0 and spi_sync_edge).
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    // Frame-level protocol state: waiting for SS, or inside an SS frame
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Width of a counter that can hold the values 0..data_width
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-stage synchroniser for an asynchronous input followed
//               by an edge detector producing single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one history register for edge detection.
    // RESET_VALUE matches the idle level so no spurious edge follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
            prev_q <= RESET_VALUE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_mode0.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_mode0
// Description : SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first. SCLK, SS
//               and MOSI are oversampled on clk_pi. Receive words leave on a
//               valid/ready port; transmit words enter a one-word holding
//               buffer through a valid/ready port.
//               Optional macro SPI_SLAVE_OVERRUN_EN adds a sticky receive
//               overrun flag (overrun_po) with clear input ovr_clr_pi.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_mode0
    import spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int                    SYNC_STAGES  = DEFAULT_SYNC_STAGES,
    parameter logic [DATA_WIDTH-1:0] IDLE_TX_WORD = '0
) (
    input  logic                  clk_pi,
    input  logic                  rst_pi,
    input  logic                  sclk_pi,
    input  logic                  ss_pi,
    input  logic                  mosi_pi,
    output logic                  miso_po,
    output logic                  miso_oe_po,
    input  logic [DATA_WIDTH-1:0] tx_data_pi,
    input  logic                  tx_valid_pi,
    output logic                  tx_ready_po,
    output logic [DATA_WIDTH-1:0] rx_data_po,
    output logic                  rx_valid_po,
    input  logic                  rx_ready_pi,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic                  ovr_clr_pi,
    output logic                  overrun_po,
`endif
    output logic                  busy_po
);

    localparam int              CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic                   rise_sclk, fall_sclk, rise_ss, fall_ss;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_sync;

    state_t                 state, next_state;
    logic                   load_tx, shift_tx, sample_rx, abort;

    logic [DATA_WIDTH-1:0]  tx_shift, rx_shift, tx_buf;
    logic                   tx_full;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   load_pending;
    logic                   word_done;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sclk_sync (
        .clk (clk_pi),
        .rst (rst_pi),
        .din (sclk_pi),
        .rise(rise_sclk),
        .fall(fall_sclk)
    );

    // SS idles high, so its chain resets high to avoid a false select edge
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_ss_sync (
        .clk (clk_pi),
        .rst (rst_pi),
        .din (ss_pi),
        .rise(rise_ss),
        .fall(fall_ss)
    );

    // MOSI needs only the synchroniser; its depth matches SCLK so the
    // sampled bit lines up with the detected rising edge
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_pi};
    end
    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    // FSM state register
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next state and datapath strobes; SCLK edges only count inside a frame
    always_comb begin
        next_state = state;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        sample_rx  = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (fall_ss) begin
                    next_state = ACTIVE;
                    load_tx    = 1'b1;
                end
            end
            ACTIVE: begin
                if (rise_ss) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end else begin
                    sample_rx = rise_sclk;
                    if (fall_sclk) begin
                        // After a completed word the next falling edge presents
                        // the first bit of the following word instead of shifting
                        if (load_pending) load_tx  = 1'b1;
                        else              shift_tx = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift registers, bit counter and word-completion tracking
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (load_tx)
                tx_shift <= tx_full ? tx_buf : IDLE_TX_WORD;
            else if (shift_tx)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};

            if (abort) begin
                // Partial word is dropped; rx_shift contents are don't-care
                bit_cnt      <= '0;
                load_pending <= 1'b0;
            end else begin
                if (load_tx) load_pending <= 1'b0;
                if (sample_rx) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt      <= '0;
                        load_pending <= 1'b1;
                        word_done    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Transmit holding buffer; a write only lands while empty, so a same-cycle
    // load consumes the previous contents and the new word stays buffered
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (tx_valid_pi && !tx_full) begin
            tx_buf  <= tx_data_pi;
            tx_full <= 1'b1;
        end else if (load_tx) begin
            tx_full <= 1'b0;
        end
    end

    // Receive output register; a new word always wins over acceptance
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            rx_data_po  <= '0;
            rx_valid_po <= 1'b0;
        end else if (word_done) begin
            rx_data_po  <= rx_shift;
            rx_valid_po <= 1'b1;
        end else if (rx_valid_po && rx_ready_pi) begin
            rx_valid_po <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    // Sticky overrun: a word lands on an unaccepted one; setting beats clearing
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi)
            overrun_po <= 1'b0;
        else if (word_done && rx_valid_po && !rx_ready_pi)
            overrun_po <= 1'b1;
        else if (ovr_clr_pi)
            overrun_po <= 1'b0;
    end
`endif

    assign miso_oe_po  = (state == ACTIVE);
    assign miso_po     = (state == ACTIVE) & tx_shift[DATA_WIDTH-1];
    assign tx_ready_po = ~tx_full;
    assign busy_po     = (state == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_mode0.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_mode0
// Description : Self-checking bench for spi_slave_mode0. Acts as a mode-0 SPI
//               master at f_sclk = f_clk/10 and scoreboards rx and MISO words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_mode0;

    logic       clk = 1'b0;
    logic       rst, sclk, ss, mosi, tx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, busy;
    logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       ovr_clr, overrun;
`endif

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];

    always #5 clk = ~clk;

    spi_slave_mode0 dut (
        .clk_pi     (clk),
        .rst_pi     (rst),
        .sclk_pi    (sclk),
        .ss_pi      (ss),
        .mosi_pi    (mosi),
        .miso_po    (miso),
        .miso_oe_po (miso_oe),
        .tx_data_pi (tx_data),
        .tx_valid_pi(tx_valid),
        .tx_ready_po(tx_ready),
        .rx_data_po (rx_data),
        .rx_valid_po(rx_valid),
        .rx_ready_pi(rx_ready),
`ifdef SPI_SLAVE_OVERRUN_EN
        .ovr_clr_pi (ovr_clr),
        .overrun_po (overrun),
`endif
        .busy_po    (busy)
    );

    // Push a word into the tx holding buffer once it is free
    task automatic tx_write(input logic [7:0] w);
        int t = 0;
        while (!tx_ready && t < 200) begin @(negedge clk); t++; end
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL tx_ready_wait: tx_ready=%b required 1", tx_ready);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master shifts nbits of w (MSB first), capturing MISO on each rising edge
    task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] cap);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            cap  = {cap[6:0], miso};
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        ss = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (5) @(negedge clk);
        ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Compare captured MISO word with the oldest expected one
    task automatic check_miso(input string name, input logic [7:0] cap);
        logic [7:0] exp;
        exp = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 8'hxx;
        n_checks++;
        if (cap !== exp) begin
            n_fails++;
            $display("FAIL %s: miso word=%h required %h", name, cap, exp);
        end
    endtask

    // Wait for rx_valid, compare data, check it holds, then accept it
    task automatic expect_rx(input string name);
        int         t = 0;
        logic [7:0] exp;
        while (!rx_valid && t < 200) begin @(negedge clk); t++; end
        exp = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 8'hxx;
        n_checks++;
        if (rx_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL %s_valid: rx_valid=%b required 1 (timeout)", name, rx_valid);
            return;
        end
        n_checks++;
        if (rx_data !== exp) begin
            n_fails++;
            $display("FAIL %s_data: rx_data=%h required %h", name, rx_data, exp);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL %s_hold: rx_valid=%b required 1", name, rx_valid);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL %s_accept: rx_valid=%b required 0", name, rx_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        ovr_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++;
        if ({miso, miso_oe, tx_ready, rx_valid, busy} !== 5'b00100) begin
            n_fails++;
            $display("FAIL reset_flags: {miso,oe,tx_ready,rx_valid,busy}=%b required 00100",
                     {miso, miso_oe, tx_ready, rx_valid, busy});
        end
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_rx_data: rx_data=%h required 00", rx_data);
        end
`ifdef SPI_SLAVE_OVERRUN_EN
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_overrun: overrun=%b required 0", overrun);
        end
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({busy, miso_oe, tx_ready} !== 3'b001) begin
            n_fails++;
            $display("FAIL reset_release: {busy,oe,tx_ready}=%b required 001",
                     {busy, miso_oe, tx_ready});
        end
    endtask

    task automatic test_basic();
        logic [7:0] cap;
        tx_write(8'h17);
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_tx_full: tx_ready=%b required 0", tx_ready);
        end
        exp_miso_q.push_back(8'h17);
        exp_rx_q.push_back(8'hA4);
        frame_start();
        n_checks++;
        if ({tx_ready, miso_oe, busy} !== 3'b111) begin
            n_fails++;
            $display("FAIL basic_select: {tx_ready,oe,busy}=%b required 111",
                     {tx_ready, miso_oe, busy});
        end
        spi_bits(8'hA4, 8, cap);
        frame_end();
        n_checks++;
        if ({miso_oe, busy} !== 2'b00) begin
            n_fails++;
            $display("FAIL basic_deselect: {oe,busy}=%b required 00", {miso_oe, busy});
        end
        check_miso("basic_miso", cap);
        expect_rx("basic_rx");
    endtask

    task automatic test_idle_word();
        logic [7:0] cap;
        exp_miso_q.push_back(8'h00);
        exp_rx_q.push_back(8'h1B);
        frame_start();
        spi_bits(8'h1B, 8, cap);
        frame_end();
        check_miso("idle_miso", cap);
        expect_rx("idle_rx");
    endtask

    task automatic test_back_to_back();
        logic [7:0] cap;
        tx_write(8'h55);
        exp_miso_q.push_back(8'h55);
        exp_miso_q.push_back(8'hAA);
        exp_rx_q.push_back(8'hA4);
        exp_rx_q.push_back(8'h1B);
        frame_start();
        tx_write(8'hAA);
        spi_bits(8'hA4, 8, cap);
        check_miso("b2b_miso0", cap);
        expect_rx("b2b_rx0");
        spi_bits(8'h1B, 8, cap);
        check_miso("b2b_miso1", cap);
        frame_end();
        expect_rx("b2b_rx1");
    endtask

    task automatic test_abort();
        logic [7:0] cap;
        frame_start();
        spi_bits(8'hFF, 5, cap);
        frame_end();
        repeat (10) @(negedge clk);
        n_checks++;
        if ({rx_valid, miso_oe, miso} !== 3'b000) begin
            n_fails++;
            $display("FAIL abort_state: {rx_valid,oe,miso}=%b required 000",
                     {rx_valid, miso_oe, miso});
        end
        exp_miso_q.push_back(8'h00);
        exp_rx_q.push_back(8'h3C);
        frame_start();
        spi_bits(8'h3C, 8, cap);
        frame_end();
        check_miso("abort_next_miso", cap);
        expect_rx("abort_next_rx");
    endtask

    task automatic test_overwrite();
        logic [7:0] cap;
        frame_start();
        spi_bits(8'h11, 8, cap);
        frame_end();
        n_checks++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
            n_fails++;
            $display("FAIL ovw_first: valid=%b data=%h required 1 11", rx_valid, rx_data);
        end
`ifdef SPI_SLAVE_OVERRUN_EN
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL ovw_no_overrun: overrun=%b required 0", overrun);
        end
`endif
        // The first word is overwritten, so only the second is expected
        exp_rx_q.push_back(8'h22);
        frame_start();
        spi_bits(8'h22, 8, cap);
        frame_end();
`ifdef SPI_SLAVE_OVERRUN_EN
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fails++;
            $display("FAIL ovw_overrun_set: overrun=%b required 1", overrun);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fails++;
            $display("FAIL ovw_overrun_sticky: overrun=%b required 1", overrun);
        end
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fails++;
            $display("FAIL ovw_overrun_clr: overrun=%b required 0", overrun);
        end
`endif
        expect_rx("ovw_rx");
    endtask

    task automatic test_reset_midword();
        logic [7:0] cap;
        frame_start();
        tx_write(8'h99);
        spi_bits(8'hC3, 4, cap);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({miso, miso_oe, tx_ready, rx_valid, busy} !== 5'b00100) begin
            n_fails++;
            $display("FAIL midrst_async: {miso,oe,tx_ready,rx_valid,busy}=%b required 00100",
                     {miso, miso_oe, tx_ready, rx_valid, busy});
        end
        ss = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        exp_miso_q.push_back(8'h00);
        exp_rx_q.push_back(8'hF0);
        frame_start();
        spi_bits(8'hF0, 8, cap);
        frame_end();
        check_miso("midrst_miso", cap);
        expect_rx("midrst_rx");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_word();
        test_back_to_back();
        test_abort();
        test_overwrite();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_mode0.md
Name: spi_slave_mode0

Overview:
SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) forming the far end of the team's SPI master link (sclk_po/ss_po/mosi_po/miso_pi).
- Oversamples SCLK, SS and MOSI on the system clock; deserialises MOSI into receive words and serialises transmit words onto MISO.
- Receive side uses a valid/ready handshake; transmit side uses a one-word holding buffer with a valid/ready handshake.
- Fits in FPGA test designs as the loopback/peer of the master or as an external-device model.

Parameters:
DATA_WIDTH, 8, bits per SPI word.
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (min 2).
IDLE_TX_WORD, 0, word shifted out when no tx word is buffered at load time.

Ports:
clk_pi  in  1  system clock; must satisfy f_clk >= 8*f_sclk
rst_pi  in  1  asynchronous active-high reset
sclk_pi  in  1  SPI clock from master
ss_pi  in  1  slave select, active low
mosi_pi  in  1  master-out serial data
miso_po  out  1  slave-out serial data
miso_oe_po  out  1  MISO drive enable (1 while selected)
tx_data_pi  in  DATA_WIDTH  word to transmit
tx_valid_pi  in  1  tx_data_pi valid
tx_ready_po  out  1  tx holding buffer empty
rx_data_po  out  DATA_WIDTH  last received word
rx_valid_po  out  1  rx_data_po valid, held until accepted
rx_ready_pi  in  1  consumer accepts rx word
busy_po  out  1  SS asserted (synchronised)

Behaviour:
- Reset values: miso_po=0, miso_oe_po=0, tx_ready_po=1, rx_data_po=0, rx_valid_po=0, busy_po=0, bit counter=0, FSM=IDLE. Reset may assert at any time, including mid-word; all state clears immediately.
- Input path: sclk, ss and mosi each pass through SYNC_STAGES flops. Edge detection is done on synchronised sclk/ss (one extra register each). rise_sclk, fall_sclk, fall_ss and rise_ss are single-cycle pulses.
- FSM IDLE:
  - On fall_ss, go to ACTIVE.
  - Load the tx shift register from the holding buffer if it is full (buffer empties, tx_ready_po=1 next cycle); otherwise load IDLE_TX_WORD.
  - Set miso_oe_po=1 and drive miso_po = shift MSB in the same cycle.
- FSM ACTIVE:
  - rise_sclk: shift synchronised mosi into rx shift register LSB; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH: copy rx shift to rx_data_po and set rx_valid_po on the next clk, bit_cnt wraps to 0, set load_pending.
  - fall_sclk with load_pending=0: shift tx register left; miso_po = new MSB.
  - fall_sclk with load_pending=1: reload the tx register from the buffer or IDLE_TX_WORD, as at SS assertion; clear load_pending. This gives back-to-back words within one SS frame.
  - rise_ss: return to IDLE, miso_oe_po=0, miso_po=0. Discard any partial rx word (no rx_valid) and clear bit_cnt and load_pending. An already-loaded tx word is lost.
- busy_po = synchronised SS active (1 in ACTIVE).
- Rx handshake:
  - rx_valid_po clears on the cycle after rx_valid_po && rx_ready_pi.
  - If a word completes on the same cycle as acceptance, the new word loads and rx_valid_po stays 1.
  - If a word completes while rx_valid_po=1 and rx_ready_pi=0, the new word overwrites rx_data_po.
- Tx handshake: the buffer accepts on tx_valid_pi && tx_ready_po; tx_ready_po=0 next cycle. If a load and a write occur in the same cycle, the load takes the old word and the new word is stored (ready stays 0).
- Latency: rx_valid_po rises SYNC_STAGES+2 clk cycles after the DATA_WIDTH-th sclk rising edge at the pin.
- SCLK edges while SS is inactive are ignored.

Optional Feature:
Macro SPI_SLAVE_OVERRUN_EN.
- With it defined: adds ports ovr_clr_pi (in, 1) and overrun_po (out, 1, reset 0).
  - overrun_po sets (sticky) when a word completes while rx_valid_po=1 and rx_ready_pi=0.
  - It clears on an ovr_clr_pi pulse. If a set and a clear occur in the same cycle, set wins.
  - Data is still overwritten.
- Without it: no extra ports; overwrite happens silently.

Decomposition:
- Package spi_slave_pkg: state_t enum {IDLE, ACTIVE}, default DATA_WIDTH/SYNC_STAGES localparams, bit-counter width function ($clog2(DATA_WIDTH+1)).
- Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiated for sclk and ss; mosi uses the synchroniser only.

Test Plan:
- Write 0x17 into the tx buffer, then master sends 0xA4 in one SS frame at f_sclk=f_clk/10 -> rx_data_po=0xA4 with a rx_valid_po pulse held until ready; MISO bits captured = 0x17; tx_ready_po returns to 1 after fall_ss.
- No tx word buffered, master sends 0x1B -> MISO captures IDLE_TX_WORD (0x00); rx_data_po=0x1B.
- Two words in one frame (0xA4, 0x1B) with tx words 0x55 then 0xAA written in between -> rx sequence 0xA4, 0x1B; MISO sequence 0x55, 0xAA.
- SS deasserted after 5 bits -> no rx_valid_po, miso_oe_po=0; the next full frame 0x3C is received correctly.
- rx_ready_pi held low across two words 0x11, 0x22 -> rx_data_po=0x22; with SPI_SLAVE_OVERRUN_EN, overrun_po=1 until an ovr_clr_pi pulse.
- rst_pi asserted mid-word (after 4 sclk edges) -> all outputs at reset values asynchronously; after release, frame 0xF0 is received correctly.
